// File: rtl/tile_load_ctrl.sv
// Streams a MATRIX_SIZE x MATRIX_SIZE matrix from a wide source memory into the tile
// input buffer, one tile row (one memory word) per beat, tiles visited row-major.
module tile_load_ctrl #(
    parameter int MATRIX_SIZE = 32,
    parameter int BUFFER_SIZE = 8,
    parameter int WIDTH       = 32,
    parameter int ADDR_W      = 16,
    parameter int IDX_W       = $clog2(BUFFER_SIZE) + 1,
    localparam int T          = MATRIX_SIZE / BUFFER_SIZE,
    localparam int TW         = (T > 1) ? $clog2(T) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic [ADDR_W-1:0]            base_addr,
    input  logic                         mode_cfg,
    input  logic [IDX_W-1:0]             offset_cfg,
    output logic                         busy,
    output logic                         done,
    output logic [TW-1:0]                tile_row,
    output logic [TW-1:0]                tile_col,
    output logic                         mem_rd_en,
    output logic [ADDR_W-1:0]            mem_rd_addr,
    input  logic [BUFFER_SIZE*WIDTH-1:0] mem_rd_data,
    output logic                         in_mode,
    output logic [IDX_W-1:0]             offset,
    output logic [IDX_W-1:0]             index_in,
    output logic [BUFFER_SIZE*WIDTH-1:0] data_in,
    output logic                         in_valid,
    output logic                         in_last,
    input  logic                         in_ready
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WAIT, S_SEND} state_t;

    state_t                   state_q, state_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [TW-1:0]            row_q, row_d;
    logic [TW-1:0]            col_q, col_d;
    logic [IDX_W-1:0]         r_q, r_d;
    logic                     rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]        rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]        base_q, base_d;
    logic                     mode_q, mode_d;
    logic [IDX_W-1:0]         offset_q, offset_d;
    logic [BUFFER_SIZE*WIDTH-1:0] data_q, data_d;
    logic                     valid_q, valid_d;
    logic                     last_q, last_d;

    logic [TW-1:0]            row_nx, col_nx;
    logic [IDX_W-1:0]         r_nx;
    logic                     row_end, matrix_end;

    // Word address of row r of tile (row, col); wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] beat_addr(
        input logic [ADDR_W-1:0] base,
        input logic [TW-1:0]     row,
        input logic [TW-1:0]     col,
        input logic [IDX_W-1:0]  r
    );
        logic [ADDR_W-1:0] off;
        off = ADDR_W'((32'(row) * BUFFER_SIZE + 32'(r)) * T + 32'(col));
        return base + off;
    endfunction

    always_comb begin
        row_end    = (r_q == IDX_W'(BUFFER_SIZE - 1));
        matrix_end = row_end && (col_q == TW'(T - 1)) && (row_q == TW'(T - 1));
        r_nx   = row_end ? '0 : r_q + IDX_W'(1);
        col_nx = col_q;
        row_nx = row_q;
        if (row_end) begin
            if (col_q == TW'(T - 1)) begin
                col_nx = '0;
                row_nx = row_q + TW'(1);
            end else begin
                col_nx = col_q + TW'(1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        row_d     = row_q;
        col_d     = col_q;
        r_d       = r_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        base_d    = base_q;
        mode_d    = mode_q;
        offset_d  = offset_q;
        data_d    = data_q;
        valid_d   = valid_q;
        last_d    = last_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d   = S_RD;
                    busy_d    = 1'b1;
                    base_d    = base_addr;
                    mode_d    = mode_cfg;
                    offset_d  = offset_cfg;
                    row_d     = '0;
                    col_d     = '0;
                    r_d       = '0;
                    rd_en_d   = 1'b1;
                    rd_addr_d = base_addr;
                end
            end
            S_RD:   state_d = S_WAIT;
            S_WAIT: begin
                data_d  = mem_rd_data;
                valid_d = 1'b1;
                last_d  = row_end;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (in_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (matrix_end) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        r_d       = r_nx;
                        col_d     = col_nx;
                        row_d     = row_nx;
                        rd_en_d   = 1'b1;
                        rd_addr_d = beat_addr(base_q, row_nx, col_nx, r_nx);
                        state_d   = S_RD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // abort wins over a simultaneous transfer: the beat is dropped and done suppressed
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            rd_en_d = 1'b0;
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
            r_q       <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            base_q    <= '0;
            mode_q    <= 1'b0;
            offset_q  <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            row_q     <= row_d;
            col_q     <= col_d;
            r_q       <= r_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            base_q    <= base_d;
            mode_q    <= mode_d;
            offset_q  <= offset_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign tile_row    = row_q;
    assign tile_col    = col_q;
    assign mem_rd_en   = rd_en_q;
    assign mem_rd_addr = rd_addr_q;
    assign in_mode     = mode_q;
    assign offset      = offset_q;
    assign index_in    = r_q;
    assign data_in     = data_q;
    assign in_valid    = valid_q;
    assign in_last     = last_q;

endmodule

// File: tb/tb_tile_load_ctrl.sv
// Directed bench for tile_load_ctrl: a matrix-level beat model checked every cycle,
// plus hand-computed addresses and cycle counts for each scenario.
module tb_tile_load_ctrl;
    localparam int MS = 32, BS = 8, WD = 32, AW = 16, IW = 4, TT = 4, TWD = 2;
    localparam int NB = TT * TT * BS;

    logic clk = 1'b0, rst = 1'b1;
    logic start = 1'b0, abort = 1'b0, mode_cfg = 1'b0, in_ready = 1'b1;
    logic [AW-1:0] base_addr = '0;
    logic [IW-1:0] offset_cfg = '0;
    logic busy, done, mem_rd_en, in_mode, in_valid, in_last;
    logic [TWD-1:0] tile_row, tile_col;
    logic [AW-1:0] mem_rd_addr;
    logic [IW-1:0] offset, index_in;
    logic [BS*WD-1:0] mem_rd_data = '0, data_in;

    tile_load_ctrl #(.MATRIX_SIZE(MS), .BUFFER_SIZE(BS), .WIDTH(WD), .ADDR_W(AW), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .base_addr(base_addr),
        .mode_cfg(mode_cfg), .offset_cfg(offset_cfg), .busy(busy), .done(done),
        .tile_row(tile_row), .tile_col(tile_col), .mem_rd_en(mem_rd_en),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .in_mode(in_mode),
        .offset(offset), .index_in(index_in), .data_in(data_in), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready)
    );

    always #5 clk = ~clk;

    int n_total = 0, n_pass = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory word a holds a in every lane; one-cycle read latency.
    function automatic logic [BS*WD-1:0] word_of(input logic [AW-1:0] a);
        logic [BS*WD-1:0] w;
        for (int k = 0; k < BS; k++) w[k*WD +: WD] = {16'd0, a};
        return w;
    endfunction
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= word_of(mem_rd_addr);

    function automatic logic [AW-1:0] exp_addr(input int base, input int beat);
        int t, r;
        t = beat / BS;
        r = beat % BS;
        return AW'(base + ((t / TT) * BS + r) * TT + (t % TT));
    endfunction

    task automatic check(input bit ok, input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Matrix-level model: current beat number, latched config, transfer bookkeeping.
    bit active = 0, done_exp = 0, done_flag = 0, busy_at_done = 1;
    int m_base = 0, m_beat = 0, start_cyc = 0, first_rd = -1, first_valid = -1, done_cyc = -1, lasts = 0;
    logic m_mode = 0;
    logic [IW-1:0] m_off = '0;
    int rd_log [0:NB-1];

    always @(negedge clk) begin
        if (rst) begin
            active = 0; done_exp = 0; m_mode = 0; m_off = '0;
        end else begin
            check(busy === active, "busy", 256'(busy), 256'(active));
            check(done === done_exp, "done", 256'(done), 256'(done_exp));
            check(in_mode === m_mode && offset === m_off, "cfg", 256'({in_mode, offset}), 256'({m_mode, m_off}));
            if (done) begin
                done_flag = 1; done_cyc = cyc - start_cyc; busy_at_done = busy;
            end
            if (!active) check(!in_valid && !mem_rd_en, "idle_quiet", 256'({in_valid, mem_rd_en}), 256'(0));
            if (active && mem_rd_en) begin
                check(mem_rd_addr === exp_addr(m_base, m_beat), "rd_addr", 256'(mem_rd_addr), 256'(exp_addr(m_base, m_beat)));
                rd_log[m_beat] = int'(mem_rd_addr);
                if (first_rd < 0) first_rd = cyc - start_cyc;
            end
            if (active && in_valid) begin
                check(data_in === word_of(exp_addr(m_base, m_beat)), "data_in", data_in, word_of(exp_addr(m_base, m_beat)));
                check(index_in === IW'(m_beat % BS), "index_in", 256'(index_in), 256'(m_beat % BS));
                check(in_last === (m_beat % BS == BS - 1), "in_last", 256'(in_last), 256'(m_beat % BS == BS - 1));
                check({tile_row, tile_col} === {TWD'(m_beat / (BS * TT)), TWD'((m_beat / BS) % TT)}, "tile",
                      256'({tile_row, tile_col}), 256'({TWD'(m_beat / (BS * TT)), TWD'((m_beat / BS) % TT)}));
                if (first_valid < 0) first_valid = cyc - start_cyc;
            end
            done_exp = 0;
            if (active) begin
                if (abort) active = 0;
                else if (in_valid && in_ready) begin
                    if (in_last) lasts++;
                    m_beat++;
                    if (m_beat == NB) begin active = 0; done_exp = 1; end
                end
            end else if (start && !abort) begin
                active = 1; m_base = int'(base_addr); m_mode = mode_cfg; m_off = offset_cfg;
                m_beat = 0; start_cyc = cyc; first_rd = -1; first_valid = -1; lasts = 0;
                done_flag = 0; done_cyc = -1; busy_at_done = 1;
                for (int i = 0; i < NB; i++) rd_log[i] = -1;
            end
        end
    end

    task automatic run_start(input logic [AW-1:0] b, input logic m, input logic [IW-1:0] o);
        @(posedge clk); #1;
        base_addr = b; mode_cfg = m; offset_cfg = o; start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic wait_done(input int exp_cyc, input string name);
        int n;
        n = 0;
        while (!done_flag && n < 2000) begin @(negedge clk); #1; n++; end
        check(done_flag, {name, "_done_seen"}, 256'(done_flag), 256'(1));
        check(done_cyc == exp_cyc, {name, "_done_cycle"}, 256'(done_cyc), 256'(exp_cyc));
        check(busy_at_done == 0, {name, "_busy_at_done"}, 256'(busy_at_done), 256'(0));
        check(m_beat == NB && lasts == NB / BS, {name, "_beats"}, 256'({m_beat, lasts}), 256'({NB, NB / BS}));
    endtask

    task automatic wait_rd(input int b);
        int n;
        n = 0;
        do begin @(negedge clk); #1; n++; end while (!(mem_rd_en && m_beat == b) && n < 1000);
        check(n < 1000, "wait_rd", 256'(n), 256'(b));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check({busy, done, mem_rd_en, in_valid, in_last, mem_rd_addr, index_in, in_mode, offset, tile_row, tile_col} == '0
              && data_in == '0, "reset_values", 256'({busy, done, mem_rd_en, in_valid, in_last, mem_rd_addr}), 256'(0));
        @(posedge clk); #1;
        rst = 0;

        // Nominal run, with a stray start and base change while busy.
        run_start(16'h0100, 1'b0, '0);
        repeat (10) @(posedge clk);
        #1; base_addr = 16'h0300; start = 1;
        @(posedge clk); #1; start = 0;
        wait_done(385, "nominal");
        check(first_rd == 1, "first_rd_cycle", 256'(first_rd), 256'(1));
        check(first_valid == 3, "first_valid_cycle", 256'(first_valid), 256'(3));
        check(rd_log[0] == 'h0100, "beat0_addr", 256'(rd_log[0]), 256'('h0100));
        check(rd_log[1] == 'h0104, "beat1_addr", 256'(rd_log[1]), 256'('h0104));
        check(rd_log[8] == 'h0101, "tile01_addr", 256'(rd_log[8]), 256'('h0101));

        // Five-cycle stall during beat 10.
        run_start(16'h0100, 1'b0, '0);
        wait_rd(10);
        @(posedge clk);
        @(posedge clk); #1; in_ready = 0;
        repeat (5) @(posedge clk);
        #1; in_ready = 1;
        wait_done(390, "stall");

        // Abort in the SEND cycle of beat 20.
        run_start(16'h0100, 1'b0, '0);
        wait_rd(20);
        @(posedge clk);
        @(posedge clk); #1; abort = 1;
        @(posedge clk); #1; abort = 0;
        check(in_valid == 0 && busy == 0, "abort_drop", 256'({in_valid, busy}), 256'(0));
        repeat (30) @(negedge clk);
        #1;
        check(done_flag == 0 && m_beat == 20, "abort_no_done", 256'({done_flag, m_beat}), 256'(20));

        // Restart after abort, config changed mid-run must not leak through.
        run_start(16'h0200, 1'b1, 4'd3);
        repeat (20) @(posedge clk);
        #1; mode_cfg = 0; offset_cfg = '0;
        wait_done(385, "cfg_hold");
        check(rd_log[0] == 'h0200, "restart_addr", 256'(rd_log[0]), 256'('h0200));
        check(in_mode == 1 && offset == 3, "cfg_after_done", 256'({in_mode, offset}), 256'({1'b1, 4'd3}));

        // Asynchronous reset in the middle of a WAIT cycle.
        run_start(16'h0100, 1'b1, 4'd5);
        wait_rd(4);
        @(posedge clk); #2;
        rst = 1;
        #1;
        check({busy, done, mem_rd_en, in_valid, in_last, mem_rd_addr, index_in, in_mode, offset, tile_row, tile_col} == '0
              && data_in == '0, "async_reset", 256'({busy, mem_rd_en, in_valid, mem_rd_addr, index_in, in_mode, offset}), 256'(0));
        @(negedge clk);
        @(posedge clk); #1;
        rst = 0;

        // Address wrap-around.
        run_start(16'hFFFE, 1'b0, '0);
        wait_done(385, "wrap");
        check(rd_log[0] == 'hFFFE, "wrap_beat0", 256'(rd_log[0]), 256'('hFFFE));
        check(rd_log[1] == 'h0002, "wrap_beat1", 256'(rd_log[1]), 256'('h0002));
        check(rd_log[8] == 'hFFFF, "wrap_tile01", 256'(rd_log[8]), 256'('hFFFF));
        check(rd_log[16] == 'h0000, "wrap_tile02", 256'(rd_log[16]), 256'('h0000));

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/tile_load_ctrl.md
# tile_load_ctrl

Sequencer that streams one MATRIX_SIZE×MATRIX_SIZE FP32 matrix from a 256-bit-wide source memory into the accelerator's tile input buffer, one BUFFER_SIZE×BUFFER_SIZE tile at a time. It generates row-beat addresses, handles the fixed one-cycle memory read latency, and drives the buffer's write handshake (index_in, in_valid, in_last, in_ready). It also latches and presents the buffer's mode and offset configuration. It sits between the accelerator's register/command front-end and the input buffer.

## Interface
- MATRIX_SIZE, 32, matrix dimension in elements; must be a multiple of BUFFER_SIZE
- BUFFER_SIZE, 8, tile dimension; one memory word holds one tile row
- WIDTH, 32, element width (FP32)
- ADDR_W, 16, source memory word-address width
- IDX_W, $clog2(BUFFER_SIZE)+1, width of index_in and offset
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle command pulse; honoured only in IDLE
- abort  in  1  cancel the running transfer
- base_addr  in  ADDR_W  word address of element (0,0)
- mode_cfg  in  1  buffer write mode; latched at start
- offset_cfg  in  IDX_W  buffer offset; latched at start
- busy  out  1  high from the accepted start until done/abort
- done  out  1  one-cycle pulse after the final beat is transferred
- tile_row, tile_col  out  $clog2(MATRIX_SIZE/BUFFER_SIZE) each  current tile coordinates
- mem_rd_en  out  1  read strobe
- mem_rd_addr  out  ADDR_W  read address
- mem_rd_data  in  BUFFER_SIZE*WIDTH  read data, valid the cycle after mem_rd_en
- in_mode  out  1  latched mode_cfg
- offset  out  IDX_W  latched offset_cfg
- index_in  out  IDX_W  row index within the current tile, 0..BUFFER_SIZE-1
- data_in  out  BUFFER_SIZE*WIDTH  row data; element k occupies bits [k*WIDTH +: WIDTH]
- in_valid  out  1  beat valid
- in_last  out  1  marks the last row of a tile; qualified by in_valid
- in_ready  in  1  buffer accepts a beat

## Operation
- Geometry:
  - T = MATRIX_SIZE/BUFFER_SIZE (tiles per side); W = T (memory words per matrix row).
  - Tiles are visited row-major, tile_col fastest; T² tiles total, BUFFER_SIZE beats each.
- Beat address: base_addr + (tile_row*BUFFER_SIZE + r)*W + tile_col, where r = index_in.
  - Computed modulo 2^ADDR_W; wrap-around is silent.
- FSM states: IDLE, RD, WAIT, SEND.
  - IDLE: start → RD. mode_cfg, offset_cfg and base_addr are latched, and counters are zeroed.
  - RD: mem_rd_en=1 with the beat address → WAIT.
  - WAIT: mem_rd_data is registered into data_in at the end of the cycle → SEND.
  - SEND: in_valid=1, and in_last=1 when r = BUFFER_SIZE-1. The beat transfers on the edge where in_valid && in_ready. Then:
    - not the last beat of the matrix: advance r (wrapping to 0 and advancing tile_col, then tile_row) and go to RD;
    - last beat of the matrix: go to IDLE and pulse done.
- While in SEND and stalled, data_in, index_in and in_last stay stable and in_valid stays high.
- abort, in any non-IDLE state: IDLE on the next edge. in_valid drops, no done pulse is issued, and a beat in flight is discarded.
- abort takes priority over a simultaneous transfer.
- start while busy is ignored; start together with abort in IDLE is ignored.
- in_mode and offset hold their latched values until the next accepted start.

## Timing
- Reset values:
  - state IDLE;
  - busy, done, mem_rd_en, in_valid, in_last = 0;
  - mem_rd_addr, index_in, data_in, in_mode, offset, tile_row, tile_col = 0.
- Reset is asynchronous and takes effect mid-transfer with no partial completion.
- Let cycle 0 be the cycle in which start is sampled:
  - busy=1 from cycle 1;
  - mem_rd_en from cycle 1;
  - first in_valid in cycle 3.
- Beat throughput is at best 1 beat per 3 cycles, and one extra cycle is added per stalled cycle of in_ready.
- Unstalled full matrix: 3·T²·BUFFER_SIZE cycles from the first RD to the final transfer. done is high in the cycle after the final transfer, and busy is 0 in that same cycle.
- All outputs are registered; no combinational path from in_ready to any output.

## Test plan
- Defaults, base_addr=0x0100, in_ready tied high, memory word a holding a in every lane:
  - 128 beats, 3 cycles apart;
  - beat 0 reads 0x0100; beat 1 reads 0x0104; the tile (0,1) first beat reads 0x0101;
  - in_last on every 8th beat; done at cycle 385; busy low at cycle 385.
- Same setup, but in_ready low for 5 cycles during beat 10: in_valid held, data_in/index_in unchanged, no duplicate or lost beat, done at cycle 390.
- abort asserted in the SEND cycle of beat 20 with in_ready=1: no transfer counted, in_valid 0 the next cycle, no done pulse; a new start then restarts from tile (0,0), r=0.
- rst pulsed asynchronously mid-WAIT: all outputs go to reset values immediately, without waiting for a clock edge.
- start repeated while busy: ignored, with no effect on addresses.
- mode_cfg=1, offset_cfg=3 at start, then changed to 0/0 mid-run: in_mode=1 and offset=3 until done.
- base_addr=0xFFFE: addresses wrap to 0x0000 onward.
